// File: rtl/arm_register_file.sv
// ARM-style register file: r0-r14 in an array, r15 aliased to the PC, separate CPSR.
// Optional macro WRITE_BYPASS_EN forwards same-cycle write data to the read ports and status outputs.
module arm_register_file #(
  parameter int          WORD_SIZE  = 32,
  parameter int          NUM_REGS   = 16,
  parameter int          ADDR_WIDTH = 4,
  parameter logic [31:0] PC_RESET   = 32'h00000000,
  parameter logic [31:0] CPSR_RESET = 32'h000000D3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_we,
  input  logic [WORD_SIZE-1:0]  rd_in,
  input  logic [ADDR_WIDTH-1:0] write_rd,
  input  logic [ADDR_WIDTH-1:0] read_rn,
  input  logic [ADDR_WIDTH-1:0] read_rm,
  input  logic [WORD_SIZE-1:0]  pc_in,
  input  logic [WORD_SIZE-1:0]  cpsr_in,
  input  logic                  pc_we,
  input  logic                  cpsr_we,
  output logic [WORD_SIZE-1:0]  rn_out,
  output logic [WORD_SIZE-1:0]  rm_out,
  output logic [WORD_SIZE-1:0]  pc_out,
  output logic [WORD_SIZE-1:0]  cpsr_out
);

  localparam logic [ADDR_WIDTH-1:0] PC_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  logic [WORD_SIZE-1:0] regs_q [NUM_REGS-1];
  logic [WORD_SIZE-1:0] regs_d [NUM_REGS-1];
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] cpsr_q, cpsr_d;

  logic rd_to_pc;
  assign rd_to_pc = rd_we && (write_rd == PC_IDX);

  always_comb begin
    regs_d = regs_q;
    pc_d   = pc_q;
    cpsr_d = cpsr_q;
    if (pc_we) pc_d = pc_in;
    // Rd port is applied after pc_we so a write to r15 overrides pc_in.
    if (rd_we) begin
      if (rd_to_pc) pc_d = rd_in;
      else          regs_d[write_rd] = rd_in;
    end
    if (cpsr_we) cpsr_d = cpsr_in;
    if (!reset) begin
      for (int i = 0; i < NUM_REGS - 1; i++) regs_d[i] = '0;
      pc_d   = WORD_SIZE'(PC_RESET);
      cpsr_d = WORD_SIZE'(CPSR_RESET);
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    pc_q   <= pc_d;
    cpsr_q <= cpsr_d;
  end

  logic [WORD_SIZE-1:0] pc_view;
  logic [WORD_SIZE-1:0] cpsr_view;

`ifdef WRITE_BYPASS_EN
  // Forwarded values are the ones that will be stored at the coming edge.
  always_comb begin
    pc_view   = pc_q;
    cpsr_view = cpsr_q;
    if (reset) begin
      if (rd_to_pc)   pc_view = rd_in;
      else if (pc_we) pc_view = pc_in;
      if (cpsr_we)    cpsr_view = cpsr_in;
    end
  end

  function automatic logic [WORD_SIZE-1:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
    if (idx == PC_IDX)                   return pc_view;
    else if (reset && rd_we && idx == write_rd) return rd_in;
    else                                 return regs_q[idx];
  endfunction
`else
  assign pc_view   = pc_q;
  assign cpsr_view = cpsr_q;

  function automatic logic [WORD_SIZE-1:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
    if (idx == PC_IDX) return pc_q;
    else               return regs_q[idx];
  endfunction
`endif

  assign rn_out   = read_port(read_rn);
  assign rm_out   = read_port(read_rm);
  assign pc_out   = pc_view;
  assign cpsr_out = cpsr_view;

endmodule

// File: tb/tb_arm_register_file.sv
// Randomized self-checking bench for arm_register_file against an array-based reference model.
module tb_arm_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_we, pc_we, cpsr_we;
  logic [31:0] rd_in, pc_in, cpsr_in;
  logic [3:0]  write_rd, read_rn, read_rm;
  logic [31:0] rn_out, rm_out, pc_out, cpsr_out;

  always #5 clk = ~clk;

  arm_register_file dut (
    .clk(clk), .reset(reset), .rd_we(rd_we), .rd_in(rd_in), .write_rd(write_rd),
    .read_rn(read_rn), .read_rm(read_rm), .pc_in(pc_in), .cpsr_in(cpsr_in),
    .pc_we(pc_we), .cpsr_we(cpsr_we), .rn_out(rn_out), .rm_out(rm_out),
    .pc_out(pc_out), .cpsr_out(cpsr_out)
  );

  // Reference model: index 15 of m_regs is the PC.
  logic [31:0] m_regs [16];
  logic [31:0] m_cpsr;
  int checks = 0;
  int errors = 0;
  int txn    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [3:0] idx);
`ifdef WRITE_BYPASS_EN
    if (reset && rd_we && idx == write_rd) return rd_in;
    if (reset && pc_we && idx == 4'd15)    return pc_in;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic [31:0] exp_pc();
`ifdef WRITE_BYPASS_EN
    if (reset && rd_we && write_rd == 4'd15) return rd_in;
    if (reset && pc_we)                      return pc_in;
`endif
    return m_regs[15];
  endfunction

  function automatic logic [31:0] exp_cpsr();
`ifdef WRITE_BYPASS_EN
    if (reset && cpsr_we) return cpsr_in;
`endif
    return m_cpsr;
  endfunction

  task automatic model_edge();
    if (!reset) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_cpsr = 32'h000000D3;
    end else begin
      if (cpsr_we) m_cpsr = cpsr_in;
      if (pc_we)   m_regs[15] = pc_in;
      if (rd_we)   m_regs[write_rd] = rd_in;
    end
  endtask

  // One transaction: settle inputs, compare outputs against the model, clock, update model.
  task automatic cycle(input bit do_check);
    #1;
    if (do_check) begin
      check("rn_out",   rn_out,   exp_read(read_rn));
      check("rm_out",   rm_out,   exp_read(read_rm));
      check("pc_out",   pc_out,   exp_pc());
      check("cpsr_out", cpsr_out, exp_cpsr());
    end
    $display("txn %0d rst=%b rd_we=%b wr=%0d rd_in=%h pc_we=%b cpsr_we=%b rn=%0d:%h rm=%0d:%h pc=%h cpsr=%h",
             txn, reset, rd_we, write_rd, rd_in, pc_we, cpsr_we, read_rn, rn_out, read_rm, rm_out,
             pc_out, cpsr_out);
    txn++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    reset = 1'b1; rd_we = 1'b0; pc_we = 1'b0; cpsr_we = 1'b0;
    rd_in = 32'h0; pc_in = 32'h0; cpsr_in = 32'h0;
  endtask

  initial begin
    idle();
    write_rd = 4'd0; read_rn = 4'd0; read_rm = 4'd0;
    @(negedge clk);

    // Reset with a write attempt pending
    reset = 1'b0; rd_we = 1'b1; rd_in = 32'd42; write_rd = 4'd3;
    pc_we = 1'b1; pc_in = 32'h77; cpsr_we = 1'b1; cpsr_in = 32'h1;
    cycle(1'b0);
    idle();
    for (int i = 0; i < 16; i++) begin
      read_rn = 4'(i); read_rm = 4'(15 - i);
      #1;
      check("rst_rn", rn_out, 32'h0);
      cycle(1'b1);
    end
    check("rst_pc", pc_out, 32'h0);
    check("rst_cpsr", cpsr_out, 32'h000000D3);

    // Sweep writes of 42 into r0..r14
    for (int i = 0; i < 15; i++) begin
      rd_we = 1'b1; rd_in = 32'd42; write_rd = 4'(i);
      read_rn = 4'(i == 0 ? 0 : i - 1); read_rm = 4'(i + 1);
      #1;
      if (i > 0) check("sweep_prev", rn_out, 32'd42);
      if (i < 14) check("sweep_unwritten", rm_out, 32'h0);
      cycle(1'b1);
    end
    idle();

    // Dual read
    rd_we = 1'b1; write_rd = 4'd3; rd_in = 32'hDEADBEEF; cycle(1'b1);
    write_rd = 4'd7; rd_in = 32'h12345678; cycle(1'b1);
    idle(); read_rn = 4'd3; read_rm = 4'd7; #1;
    check("dual_rn", rn_out, 32'hDEADBEEF);
    check("dual_rm", rm_out, 32'h12345678);
    read_rn = 4'd7; #1;
    check("same_rn", rn_out, 32'h12345678);
    check("same_rm", rm_out, 32'h12345678);

    // PC and CPSR ports
    pc_we = 1'b1; pc_in = 32'h100; cycle(1'b1);
    idle(); read_rn = 4'd15; #1;
    check("pc_write", pc_out, 32'h100);
    check("pc_rn15", rn_out, 32'h100);
    cpsr_we = 1'b1; cpsr_in = 32'hF0000010; read_rn = 4'd3; cycle(1'b1);
    idle(); #1;
    check("cpsr_write", cpsr_out, 32'hF0000010);
    check("cpsr_gpr", rn_out, 32'hDEADBEEF);

    // Rd port beats pc_in on r15
    rd_we = 1'b1; write_rd = 4'd15; rd_in = 32'h200; pc_we = 1'b1; pc_in = 32'h300;
    cycle(1'b1);
    idle(); #1;
    check("collision_pc", pc_out, 32'h200);

    // Same-cycle read of the write target
    rd_we = 1'b1; write_rd = 4'd5; rd_in = 32'h11; cycle(1'b1);
    rd_in = 32'h55; read_rn = 4'd5; #1;
`ifdef WRITE_BYPASS_EN
    check("rw_before", rn_out, 32'h55);
`else
    check("rw_before", rn_out, 32'h11);
`endif
    cycle(1'b1);
    idle(); #1;
    check("rw_after", rn_out, 32'h55);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 31) != 0);
      rd_we    = $urandom_range(0, 1) == 1;
      pc_we    = $urandom_range(0, 3) == 0;
      cpsr_we  = $urandom_range(0, 3) == 0;
      rd_in    = $urandom;
      pc_in    = $urandom;
      cpsr_in  = $urandom;
      write_rd = 4'($urandom_range(0, 15));
      read_rn  = ($urandom_range(0, 3) == 0) ? write_rd : 4'($urandom_range(0, 15));
      read_rm  = 4'($urandom_range(0, 15));
      cycle(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm_register_file.md
Name: arm_register_file

Overview:
- ARM-style architectural register file for the CPU datapath.
- Holds 16 × 32-bit general registers (r0–r14 plus r15 aliased to the PC) and a separate 32-bit CPSR.
- Provides one synchronous write port (Rd), two combinational read ports (Rn, Rm), and dedicated PC and CPSR write/read ports for fetch and flag logic.

Parameters:
WORD_SIZE, 32, data width of every register and port
NUM_REGS, 16, number of architectural registers including r15/PC
ADDR_WIDTH, 4, register address width (log2 NUM_REGS)
PC_RESET, 32'h00000000, PC value loaded on reset
CPSR_RESET, 32'h000000D3, CPSR value loaded on reset (SVC mode, IRQ/FIQ masked)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
rd_we  input  1  write enable for Rd port
rd_in  input  WORD_SIZE  data to write to register write_rd
write_rd  input  ADDR_WIDTH  destination register index
read_rn  input  ADDR_WIDTH  read port A index
read_rm  input  ADDR_WIDTH  read port B index
pc_in  input  WORD_SIZE  next PC value
cpsr_in  input  WORD_SIZE  next CPSR value
pc_we  input  1  PC write enable
cpsr_we  input  1  CPSR write enable
rn_out  output  WORD_SIZE  contents of register read_rn
rm_out  output  WORD_SIZE  contents of register read_rm
pc_out  output  WORD_SIZE  current PC
cpsr_out  output  WORD_SIZE  current CPSR

Behaviour:
- One clock (clk), reset synchronous and active-low: when reset==0 at a rising edge, r0–r14 ← 0, PC ← PC_RESET, CPSR ← CPSR_RESET. All writes that cycle are ignored.
- Reset has priority over every enable. Reset mid-operation discards any pending write in that cycle.
- Outputs after reset: rn_out/rm_out = 0 for indices 0–14, PC_RESET for index 15; pc_out = PC_RESET; cpsr_out = CPSR_RESET.
- Storage: r0–r14 in an array. r15 has no separate storage; it is the PC register.
- Rd write: at a rising edge with reset==1 and rd_we==1, reg[write_rd] ← rd_in. Write latency is 1 cycle; the new value is visible on the read ports after that edge.
- write_rd==15 with rd_we==1 writes the PC.
- PC write: pc_we==1 → PC ← pc_in.
- Simultaneous rd_we (write_rd==15) and pc_we: the Rd port wins (PC ← rd_in). pc_in is discarded.
- CPSR write: cpsr_we==1 → CPSR ← cpsr_in. It is independent of the Rd port; no register index reaches the CPSR.
- Reads are combinational (asynchronous). rn_out = reg[read_rn], rm_out = reg[read_rm]. Index 15 returns the PC.
- Both read ports may address the same register; both then return identical data.
- pc_out and cpsr_out continuously reflect the stored values.
- Same-cycle write/read to the same index: the read returns the old (pre-edge) value unless WRITE_BYPASS_EN is defined.
- No undefined indices: all 16 addresses are valid. No arithmetic is performed; values are stored bit-exact.
- rd_we==0, pc_we==0, cpsr_we==0: all state holds.

Optional Feature:
- Macro WRITE_BYPASS_EN.
- Defined: the read ports forward write data combinationally.
  - If rd_we==1, reset==1 and read_rn==write_rd, then rn_out = rd_in. Same rule for rm_out with read_rm.
  - For index 15 with pc_we==1 and no Rd write to 15, the read ports and pc_out forward pc_in.
  - With cpsr_we==1, cpsr_out forwards cpsr_in.
- Not defined: no forwarding. Outputs reflect stored state only.
- Sequential state update is identical in both builds.

Test Plan:
- Reset: hold reset=0 for one edge with rd_we=1, rd_in=42 → all reads of r0–r14 = 0; pc_out=0x0; cpsr_out=0xD3; no write occurred.
- Sweep: reset=1, rd_we=1, rd_in=42, write_rd stepping 0..14 one per cycle, read_rn = previous index → each register reads 42 the cycle after its write; unwritten registers still read 0.
- Dual read: write r3=0xDEADBEEF and r7=0x12345678, then read_rn=3, read_rm=7 → rn_out=0xDEADBEEF, rm_out=0x12345678. Then read_rn=read_rm=7 → both 0x12345678.
- PC/CPSR: pc_we=1, pc_in=0x100 → pc_out=0x100 and read_rn=15 returns 0x100. cpsr_we=1, cpsr_in=0xF0000010 → cpsr_out=0xF0000010; GPRs unchanged.
- Collision: rd_we=1, write_rd=15, rd_in=0x200 with pc_we=1, pc_in=0x300 → pc_out=0x200.
- Same-cycle read of write target: write_rd=read_rn=5, rd_in=0x55, old r5=0x11 → before the edge, rn_out=0x11 without WRITE_BYPASS_EN and 0x55 with it. After the edge, rn_out=0x55 in both builds.
